// File: rtl/pong_key_scheduler.sv
// PS/2 scan-code scheduler for Pong: decodes make/break bytes, tracks held keys,
// queues control keys and emits at most one command per frame.
module pong_key_scheduler #(
    parameter int FIFO_DEPTH    = 4,
    parameter int REPEAT_FRAMES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       done,
    input  logic [7:0] scan_code,
    input  logic       frame_tick,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic       fifo_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [5:0]    RELOAD     = 6'(REPEAT_FRAMES - 1);

    typedef enum logic [1:0] {DEC_IDLE, DEC_BREAK, DEC_EXT, DEC_EXT_BREAK} dec_state_t;

    dec_state_t       dec_state;
    logic             done_q;
    logic             byte_valid;
    logic [7:0]       byte_q;
    logic [7:0]       held;
    logic [5:0]       p1_count;
    logic [5:0]       p2_count;
    logic             last_p2;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    fifo_count;

    logic       ev_make, ev_break, key_hit, fresh_make;
    logic [2:0] key_idx;
    logic       push, pop, fifo_write;
    logic       p1_elig, p2_elig, serve_p1, serve_p2;
    logic       p1_fresh, p2_fresh;
    logic [7:0] p1_code, p2_code;

    // Held-bit index: 0..3 are paddle keys (P1 L/R, P2 L/R), 4..7 control keys.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        key_hit = 1'b1;
        key_idx = 3'd0;
        case (byte_q)
            8'h1C: key_idx = 3'd0;
            8'h23: key_idx = 3'd1;
            8'h3B: key_idx = 3'd2;
            8'h4B: key_idx = 3'd3;
            8'h76: key_idx = 3'd4;
            8'h29: key_idx = 3'd5;
            8'h16: key_idx = 3'd6;
            8'h1E: key_idx = 3'd7;
            default: key_hit = 1'b0;
        endcase
    end

    always_comb begin
        ev_make  = 1'b0;
        ev_break = 1'b0;
        if (byte_valid) begin
            case (dec_state)
                DEC_IDLE:  ev_make  = (byte_q != 8'hE0) && (byte_q != 8'hF0);
                DEC_BREAK: ev_break = 1'b1;
                default:   ;
            endcase
        end
    end

    assign fresh_make = ev_make && key_hit && !held[key_idx];
    assign push       = fresh_make && key_idx[2];
    assign p1_fresh   = fresh_make && !key_idx[2] && !key_idx[1];
    assign p2_fresh   = fresh_make && !key_idx[2] &&  key_idx[1];

    // Opposing directions held together cancel; a player needs exactly one.
    assign p1_elig  = (held[0] ^ held[1]) && (p1_count == 6'd0);
    assign p2_elig  = (held[2] ^ held[3]) && (p2_count == 6'd0);
    assign p1_code  = held[0] ? 8'h1C : 8'h23;
    assign p2_code  = held[2] ? 8'h3B : 8'h4B;

    assign pop        = frame_tick && (fifo_count != '0);
    assign serve_p1   = frame_tick && !pop && p1_elig && (!p2_elig ||  last_p2);
    assign serve_p2   = frame_tick && !pop && p2_elig && (!p1_elig || !last_p2);
    assign fifo_write = push && ((fifo_count != FULL_COUNT) || pop);

    // NOTE: FIFO storage has no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (fifo_write) fifo_mem[wr_ptr] <= byte_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done_q        <= 1'b1;
            byte_valid    <= 1'b0;
            byte_q        <= 8'h00;
            dec_state     <= DEC_IDLE;
            held          <= 8'h00;
            p1_count      <= 6'd0;
            p2_count      <= 6'd0;
            last_p2       <= 1'b1;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            fifo_count    <= '0;
            cmd_valid     <= 1'b0;
            cmd_code      <= 8'h00;
            fifo_overflow <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            done_q        <= done;
            byte_valid    <= done && !done_q;
            if (done && !done_q) byte_q <= scan_code;
            cmd_valid     <= 1'b0;
            fifo_overflow <= push && !fifo_write;

            if (byte_valid) begin
                case (dec_state)
                    DEC_IDLE:  dec_state <= (byte_q == 8'hE0) ? DEC_EXT :
                                            (byte_q == 8'hF0) ? DEC_BREAK : DEC_IDLE;
                    DEC_EXT:   dec_state <= (byte_q == 8'hF0) ? DEC_EXT_BREAK : DEC_IDLE;
                    default:   dec_state <= DEC_IDLE;
                endcase
            end
            if (ev_make && key_hit)  held[key_idx] <= 1'b1;
            if (ev_break && key_hit) held[key_idx] <= 1'b0;

            if (pop) begin
                cmd_valid <= 1'b1;
                cmd_code  <= fifo_mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
            end else if (serve_p1) begin
                cmd_valid <= 1'b1;
                cmd_code  <= p1_code;
                last_p2   <= 1'b0;
            end else if (serve_p2) begin
                cmd_valid <= 1'b1;
                cmd_code  <= p2_code;
                last_p2   <= 1'b1;
            end

            if (fifo_write) wr_ptr <= wr_ptr + 1'b1;
            fifo_count <= fifo_count + CW'(fifo_write) - CW'(pop);

            // A fresh press overrides the frame update so the move is immediate.
            if (p1_fresh)
                p1_count <= 6'd0;
            else if (frame_tick)
                p1_count <= serve_p1 ? RELOAD : (p1_count != 6'd0 ? p1_count - 6'd1 : 6'd0);
            if (p2_fresh)
                p2_count <= 6'd0;
            else if (frame_tick)
                p2_count <= serve_p2 ? RELOAD : (p2_count != 6'd0 ? p2_count - 6'd1 : 6'd0);
        end
    end

endmodule

// File: doc/pong_key_scheduler.md
# pong_key_scheduler

Sits between the PS/2 byte receiver and the Pong game state machine. Decodes raw scan-code bytes into make/break events, tracks held keys, buffers control keys (ESC, SPACE, 1, 2) in a small FIFO and emits at most one command per video frame. Control keys have priority. Otherwise player-1 and player-2 paddle moves are served round-robin, each rate-limited to one step per REPEAT_FRAMES frames.

## Interface
- FIFO_DEPTH, 4, control-key FIFO entries (power of two, 2..16)
- REPEAT_FRAMES, 4, minimum frames between two move commands of the same player (1..63)
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low
- done  input  1  level from PS/2 receiver; a rising edge marks scan_code valid
- scan_code  input  8  received byte, stable while done high
- frame_tick  input  1  one-cycle pulse per frame (pixel 0,0 of active zone)
- cmd_valid  output  1  one-cycle pulse: cmd_code is a command for this frame
- cmd_code  output  8  scan code to act on (1C/23 P1 left/right, 3B/4B P2 left/right, 76/29/16/1E control)
- fifo_overflow  output  1  one-cycle pulse when a control key is dropped (FIFO full)

## Operation
- Byte capture: done registered; byte accepted on cycle where done=1 and done_q=0.
- Decoder FSM (advances only on accepted bytes):
  - IDLE: E0 -> EXT; F0 -> BREAK; else make(code) -> IDLE.
  - BREAK: break(code) -> IDLE.
  - EXT: F0 -> EXT_BREAK; else ignore -> IDLE.
  - EXT_BREAK: ignore -> IDLE.
- Held bits for 1C, 23, 3B, 4B, 76, 29, 16, 1E. Make sets the bit, break clears it. Unlisted codes are ignored.
- Control key make with held bit previously 0 -> push to FIFO. Typematic repeats (make while held) do not push.
- Move key make with held bit previously 0 -> that player's repeat counter forced to 0 (immediate eligibility).
- Player direction: left-only held -> left; right-only -> right; both or none -> no request.
- Player eligible when it has a direction and its repeat counter = 0.
- On frame_tick, decide using register state before this cycle's byte update:
  - FIFO non-empty -> pop head, emit it. Move counters still decrement but no move is served.
  - Else if both players eligible -> serve the one not served last (rr pointer).
  - Else if one player eligible -> serve it.
  - Else nothing is emitted.
  - A served player loads counter REPEAT_FRAMES-1 and rr points to it. Non-served nonzero counters decrement by 1 per frame_tick, saturating at 0.
- FIFO full with push and no pop -> entry dropped, fifo_overflow pulses. Push and pop in the same cycle with FIFO full -> both performed, no overflow.

## Timing
- cmd_valid/cmd_code registered: asserted the cycle after frame_tick, for exactly one cycle. cmd_code holds its value afterwards.
- Byte to held-bit/FIFO update: 2 cycles after the done rising edge (1 edge-detect, 1 decode).
- Byte accepted on the same cycle as frame_tick: the scheduling decision ignores it; it takes effect on the next frame.
- Reset values: cmd_valid 0, cmd_code 00, fifo_overflow 0, FIFO empty, held bits 0, counters 0, decoder IDLE, rr = player 2 (so player 1 wins the first tie).
- Reset mid-operation clears all state immediately. A done level already high at reset release is not counted as an edge (done_q resets to 1).

## Test plan
- Bytes 1C, then four frame_ticks, REPEAT_FRAMES=4 -> cmd 1C after tick 1 only; tick 5 -> 1C again; then F0 1C -> no further moves.
- 1C and 4B held, eight ticks -> 1C, 4B, none, none, 1C, 4B, none, none (first tie goes to player 1).
- 29 make while 1C held, tick -> cmd 29. Next tick -> 1C; player 1 counter was 0 and did not reload during the control frame.
- Seven distinct control makes (16 1E 29 76 16... with breaks between) with no tick, FIFO_DEPTH=4 -> three fifo_overflow pulses; next four ticks emit the first four in order.
- E0 1C, E0 F0 1C, 1C 23 held together, tick -> no cmd_valid (extended codes ignored, conflicting directions cancel).
- Reset asserted while FIFO holds 2 entries and done is high -> all outputs 0, FIFO empty; after release, no byte captured until done falls and rises.
